// File: rtl/branch_resolve_unit.sv
// Execute-stage branch/jump resolution: computes taken/target, checks the fetch
// prediction, raises a one-cycle redirect plus a multi-cycle flush on mispredict.
module branch_resolve_unit #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic [31:0] in_imm,
    input  logic        in_pred_taken,
    input  logic [31:0] in_pred_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_taken,
    output logic [31:0] out_link,
    output logic        out_illegal,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic [31:0] perf_branches,
    output logic [31:0] perf_mispredicts
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned CW   = 4;

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;

    logic            w_eq;
    logic            w_lt;
    logic            w_ltu;
    logic            w_taken;
    logic            w_illegal;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_pc4;
    logic [XLEN-1:0] w_next_pc;
    logic [XLEN-1:0] w_pred_pc;
    logic            w_mispredict;
    logic            w_accept;

    assign w_eq  = (in_rs1 == in_rs2);
    assign w_lt  = ($signed(in_rs1) < $signed(in_rs2));
    assign w_ltu = (in_rs1 < in_rs2);

    // Outcome and target decode
    always_comb begin
        w_taken   = 1'b0;
        w_illegal = 1'b0;
        w_target  = in_pc + in_imm;
        unique case (in_op)
            2'b00: begin
                unique case (in_funct3)
                    3'b000:  w_taken = w_eq;
                    3'b001:  w_taken = ~w_eq;
                    3'b100:  w_taken = w_lt;
                    3'b101:  w_taken = ~w_lt;
                    3'b110:  w_taken = w_ltu;
                    3'b111:  w_taken = ~w_ltu;
                    default: w_illegal = 1'b1;
                endcase
            end
            2'b01: w_taken = 1'b1;
            2'b10: begin
                w_taken  = 1'b1;
                w_target = (in_rs1 + in_imm) & ~XLEN'(1);
            end
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_pc4        = in_pc + XLEN'(4);
    assign w_next_pc    = w_taken ? w_target : w_pc4;
    assign w_pred_pc    = in_pred_taken ? in_pred_target : w_pc4;
    assign w_mispredict = ~w_illegal & (w_next_pc != w_pred_pc);

    // During flush every offered input is swallowed, so ready is unconditional
    assign in_ready = (r_state == ST_FLUSH) | ~out_valid | out_ready;
    assign w_accept = in_valid & in_ready & (r_state == ST_RUN);
    assign flush    = (r_state == ST_FLUSH);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            ST_RUN: begin
                if (w_accept && w_mispredict) begin
                    w_state_nxt = ST_FLUSH;
                    w_cnt_nxt   = CW'(FLUSH_CYCLES);
                end
            end
            ST_FLUSH: begin
                if (r_cnt <= CW'(1)) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output register, redirect pulse and event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid        <= 1'b0;
            out_taken        <= 1'b0;
            out_link         <= '0;
            out_illegal      <= 1'b0;
            redirect_valid   <= 1'b0;
            redirect_pc      <= '0;
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else begin
            redirect_valid <= w_accept & w_mispredict;
            if (w_accept) begin
                out_valid   <= 1'b1;
                out_taken   <= w_taken;
                out_link    <= w_pc4;
                out_illegal <= w_illegal;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (w_accept && w_mispredict) begin
                redirect_pc      <= w_next_pc;
                perf_mispredicts <= perf_mispredicts + XLEN'(1);
            end
            if (w_accept && !w_illegal) begin
                perf_branches <= perf_branches + XLEN'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed scenarios followed by
// randomized traffic checked against a behavioural resolution model.
module tb_branch_resolve_unit;

    localparam int unsigned FC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [2:0]  in_funct3;
    logic [31:0] in_pc, in_rs1, in_rs2, in_imm;
    logic        in_pred_taken;
    logic [31:0] in_pred_target;
    logic        out_valid;
    logic        out_ready;
    logic        out_taken;
    logic [31:0] out_link;
    logic        out_illegal;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [31:0] perf_branches, perf_mispredicts;

    branch_resolve_unit #(.FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_funct3(in_funct3),
        .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_taken(out_taken), .out_link(out_link), .out_illegal(out_illegal),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush(flush),
        .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        taken;
        logic [31:0] link;
        logic        illegal;
        logic        mis;
        logic [31:0] npc;
    } exp_t;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural resolution straight from the RV32I branch/jump rules
    function automatic exp_t resolve(input logic [1:0] op, input logic [2:0] f3,
                                     input logic [31:0] pc, input logic [31:0] a,
                                     input logic [31:0] b, input logic [31:0] imm,
                                     input logic pt, input logic [31:0] ptgt);
        exp_t e;
        logic [31:0] tgt;
        logic [31:0] pred;
        int signed sa, sb;
        sa = a;
        sb = b;
        e.taken = 1'b0;
        e.illegal = 1'b0;
        e.link = pc + 32'd4;
        tgt = pc + imm;
        if (op == 2'd0) begin
            case (f3)
                3'd0: e.taken = (a == b);
                3'd1: e.taken = (a != b);
                3'd4: e.taken = (sa < sb);
                3'd5: e.taken = (sa >= sb);
                3'd6: e.taken = (a < b);
                3'd7: e.taken = (a >= b);
                default: e.illegal = 1'b1;
            endcase
        end else if (op == 2'd1) begin
            e.taken = 1'b1;
        end else if (op == 2'd2) begin
            e.taken = 1'b1;
            tgt = (a + imm) & 32'hFFFF_FFFE;
        end else begin
            e.illegal = 1'b1;
        end
        e.npc = e.taken ? tgt : pc + 32'd4;
        pred = pt ? ptgt : pc + 32'd4;
        e.mis = !e.illegal && (e.npc != pred);
        return e;
    endfunction

    exp_t        sb_q[$];
    bit          m_live = 0;
    bit          m_took = 0;
    bit          m_occ = 0;
    bit          m_redir = 0;
    logic [31:0] m_rpc = 0;
    int          m_flush = 0;
    logic [31:0] m_br = 0;
    logic [31:0] m_mp = 0;

    // Reference: decide acceptance from the model, push expectations
    always @(posedge clk) begin
        exp_t e;
        bit   rdy, redir_n;
        m_took = 0;
        if (rst) begin
            m_live = 1; m_occ = 0; m_redir = 0; m_rpc = 0;
            m_flush = 0; m_br = 0; m_mp = 0;
            sb_q.delete();
        end else if (m_live) begin
            rdy = (m_flush > 0) || !m_occ || out_ready;
            redir_n = 0;
            if (in_valid && rdy && m_flush == 0) begin
                e = resolve(in_op, in_funct3, in_pc, in_rs1, in_rs2, in_imm,
                            in_pred_taken, in_pred_target);
                sb_q.push_back(e);
                m_took = 1;
                if (!e.illegal) m_br++;
                if (e.mis) begin
                    m_mp++;
                    redir_n = 1;
                    m_rpc = e.npc;
                end
            end
            if (m_took) m_occ = 1;
            else if (out_ready) m_occ = 0;
            if (m_flush > 0) m_flush--;
            if (redir_n) m_flush = FC;
            m_redir = redir_n;
        end
    end

    // Monitor: compare control outputs and pop retiring results
    always @(negedge clk) begin
        exp_t e;
        if (m_live && !rst) begin
            chk("in_ready", 32'(in_ready), 32'((m_flush > 0) || !m_occ || out_ready));
            chk("out_valid", 32'(out_valid), 32'(m_occ));
            chk("flush", 32'(flush), 32'(m_flush > 0));
            chk("redirect_valid", 32'(redirect_valid), 32'(m_redir));
            if (m_redir) chk("redirect_pc", redirect_pc, m_rpc);
            chk("perf_branches", perf_branches, m_br);
            chk("perf_mispredicts", perf_mispredicts, m_mp);
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("out_taken", 32'(out_taken), 32'(e.taken));
                    chk("out_link", out_link, e.link);
                    chk("out_illegal", 32'(out_illegal), 32'(e.illegal));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                         input logic pt, input logic [31:0] ptgt, output int cyc);
        in_op = op; in_funct3 = f3; in_pc = pc; in_rs1 = a; in_rs2 = b;
        in_imm = imm; in_pred_taken = pt; in_pred_target = ptgt;
        in_valid = 1'b1;
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!m_took && cyc < 50);
        if (!m_took) chk("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        int cyc;
        int pulses;
        exp_t e;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_op = '0; in_funct3 = '0; in_pc = '0; in_rs1 = '0; in_rs2 = '0;
        in_imm = '0; in_pred_taken = 1'b0; in_pred_target = '0;
        repeat (3) step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_link", out_link, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        out_ready = 1'b1;
        step();

        // BEQ predicted correctly
        issue(2'd0, 3'd0, 32'h100, 32'd5, 32'd5, 32'h20, 1'b1, 32'h120, cyc);
        chk("beq_taken", 32'(out_taken), 32'd1);
        chk("beq_link", out_link, 32'h104);
        chk("beq_no_redirect", 32'(redirect_valid), 32'd0);
        chk("beq_perf_br", perf_branches, 32'd1);

        // Signed BLT taken against a not-taken prediction
        issue(2'd0, 3'd4, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0, 32'h0, cyc);
        chk("blt_redirect", 32'(redirect_valid), 32'd1);
        chk("blt_redirect_pc", redirect_pc, 32'h240);
        chk("blt_flush", 32'(flush), 32'd1);
        issue(2'd0, 3'd0, 32'h240, 32'd0, 32'd0, 32'h8, 1'b1, 32'h248, cyc);
        chk("flush_discard_cycles", 32'(cyc), 32'd3);

        // Unsigned BLTU not taken against a taken prediction
        issue(2'd0, 3'd6, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b1, 32'h340, cyc);
        chk("bltu_redirect_pc", redirect_pc, 32'h304);
        chk("bltu_perf_mp", perf_mispredicts, 32'd2);
        repeat (4) step();

        // JALR clears bit 0 of the target
        issue(2'd2, 3'd0, 32'h400, 32'h1003, 32'd0, 32'd0, 1'b1, 32'h1002, cyc);
        chk("jalr_no_redirect", 32'(redirect_valid), 32'd0);
        issue(2'd2, 3'd0, 32'h404, 32'h1003, 32'd0, 32'd0, 1'b1, 32'h1003, cyc);
        out_ready = 1'b0;
        chk("jalr_redirect_pc", redirect_pc, 32'h1002);
        pulses = int'(redirect_valid);
        repeat (5) begin
            step();
            pulses += int'(redirect_valid);
        end
        chk("stall_redirect_pulses", 32'(pulses), 32'd1);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        step();

        // Illegal funct3 on a branch
        issue(2'd0, 3'd2, 32'h500, 32'd1, 32'd1, 32'h10, 1'b1, 32'h999, cyc);
        chk("ill_flag", 32'(out_illegal), 32'd1);
        chk("ill_taken", 32'(out_taken), 32'd0);
        chk("ill_no_redirect", 32'(redirect_valid), 32'd0);
        chk("ill_perf_br", perf_branches, 32'd6);

        // Reset in the middle of a flush with the output stalled
        issue(2'd0, 3'd0, 32'h600, 32'd1, 32'd1, 32'h10, 1'b0, 32'h0, cyc);
        out_ready = 1'b0;
        chk("pre_rst_flush", 32'(flush), 32'd1);
        rst = 1'b1;
        step();
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_flush", 32'(flush), 32'd0);
        chk("mid_rst_redirect", 32'(redirect_valid), 32'd0);
        chk("mid_rst_redirect_pc", redirect_pc, 32'd0);
        chk("mid_rst_perf_br", perf_branches, 32'd0);
        chk("mid_rst_perf_mp", perf_mispredicts, 32'd0);
        chk("mid_rst_link", out_link, 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        step();

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 499) == 0);
            in_op     = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            in_funct3 = 3'($urandom);
            in_pc     = {$urandom} & 32'hFFFF_FFFC;
            in_rs1    = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 7)) - 32'd4 : $urandom;
            in_rs2    = ($urandom_range(0, 2) == 0) ? in_rs1 : 32'($urandom_range(0, 7)) - 32'd4;
            in_imm    = 32'($signed(13'($urandom)));
            e = resolve(in_op, in_funct3, in_pc, in_rs1, in_rs2, in_imm, 1'b1, 32'h0);
            case ($urandom_range(0, 3))
                0: begin in_pred_taken = 1'b1; in_pred_target = $urandom; end
                1: begin in_pred_taken = 1'b0; in_pred_target = $urandom; end
                default: begin
                    in_pred_taken = 1'b1;
                    in_pred_target = e.npc;
                end
            endcase
            step();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (20) step();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
